char_motion_ctrl: RTL and testbench

- Motion scheduler between the keypad decoder and the character position register.
- Divides sys_clk into a motion tick and runs the jump/fall state machine.
- Merges held direction keys with gravity and vets every move against collision flags and screen limits.
- Issues at most one vertical and one horizontal single-pixel step pulse per tick; the position register applies them.

---
 rtl/char_motion_ctrl_if.sv | 28 ++
 rtl/char_motion_ctrl.sv | 133 +++++++++++++
 tb/tb_char_motion_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/char_motion_ctrl_if.sv
// Bundle between keypad/collision logic, the motion scheduler and the position register.
// Latency: none; this is just wiring.
// Backpressure: none; all signals are levels or single-cycle pulses.
interface char_motion_ctrl_if;
    logic       en;
    logic [1:0] key_lr;     // {left, right}
    logic       jump_btn;
    logic [9:0] char_x;
    logic       blk_up;
    logic       blk_down;
    logic       blk_left;
    logic       blk_right;
    logic [3:0] step;       // {up, down, left, right}
    logic [1:0] state;
    logic [5:0] rise_cnt;

    // Driver side: keypad decoder, collision map, position register feedback.
    modport master (
        output en, key_lr, jump_btn, char_x, blk_up, blk_down, blk_left, blk_right,
        input  step, state, rise_cnt
    );

    // Scheduler side.
    modport slave (
        input  en, key_lr, jump_btn, char_x, blk_up, blk_down, blk_left, blk_right,
        output step, state, rise_cnt
    );
endinterface

// File: rtl/char_motion_ctrl.sv
// Motion scheduler: divides sys_clk to a motion tick, runs jump/fall FSM, emits vetted step pulses.
// Latency: decisions taken on the tick cycle, step pulse visible the following cycle for one cycle.
// Backpressure: none; en=0 freezes counter/FSM and suppresses all pulses.
module char_motion_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int JUMP_H   = 48,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    char_motion_ctrl_if.slave   bus
);

    localparam int              CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [5:0]      RISE_MAX  = 6'(JUMP_H);
    localparam logic [9:0]      X_LO      = 10'(X_MIN);
    localparam logic [9:0]      X_HI      = 10'(X_MAX);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10,
        ST_BAD    = 2'b11
    } mstate_t;

    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic          jump_q;
    logic          jump_lat;
    logic          jump_edge;
    logic          jump_req;
    logic [1:0]    hz_step;
    mstate_t       st_q;
    logic [5:0]    rise_q;
    logic [3:0]    step_q;

    assign tick      = bus.en && (tick_cnt == TICK_LAST);
    assign jump_edge = bus.jump_btn && !jump_q;
    // An edge arriving on the tick cycle itself is honoured by that tick.
    assign jump_req  = jump_lat || jump_edge;

    // Motion tick divider; holds its value while paused so resuming keeps the phase.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tick_cnt <= '0;
        end else if (bus.en) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        end
    end

    // Jump edge detector and one-tick latch; pause forces the latch clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            jump_q   <= 1'b0;
            jump_lat <= 1'b0;
        end else begin
            jump_q <= bus.jump_btn;
            if (!bus.en || tick) begin
                jump_lat <= 1'b0;
            end else if (jump_edge) begin
                jump_lat <= 1'b1;
            end
        end
    end

    // Horizontal vetting: only a single held direction moves, never past walls or screen edge.
    always_comb begin
        hz_step = 2'b00;
        case (bus.key_lr)
            2'b10: if (!bus.blk_left  && (bus.char_x > X_LO)) hz_step = 2'b10;
            2'b01: if (!bus.blk_right && (bus.char_x < X_HI)) hz_step = 2'b01;
            default: hz_step = 2'b00;
        endcase
    end

    // Vertical FSM with registered state, rise counter and step pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_q   <= ST_FALL;
            rise_q <= 6'd0;
            step_q <= 4'b0000;
        end else begin
            step_q <= 4'b0000;
            if (tick) begin
                case (st_q)
                    ST_GROUND: begin
                        if (!bus.blk_down) begin
                            st_q   <= ST_FALL;
                            step_q <= {2'b00, hz_step};
                        end else if (jump_req && !bus.blk_up) begin
                            st_q   <= ST_RISE;
                            rise_q <= 6'd1;
                            step_q <= {2'b10, hz_step};
                        end else begin
                            step_q <= {2'b00, hz_step};
                        end
                    end
                    ST_RISE: begin
                        if (bus.blk_up || (rise_q == RISE_MAX)) begin
                            // Head bump or apex: start falling, keep rise_cnt for visibility.
                            st_q   <= ST_FALL;
                            step_q <= {2'b00, hz_step};
                        end else begin
                            rise_q <= rise_q + 6'd1;
                            step_q <= {2'b10, hz_step};
                        end
                    end
                    ST_FALL: begin
                        if (bus.blk_down) begin
                            st_q   <= ST_GROUND;
                            rise_q <= 6'd0;
                            step_q <= {2'b00, hz_step};
                        end else begin
                            step_q <= {2'b01, hz_step};
                        end
                    end
                    default: begin
                        // Illegal encoding recovers through FALL.
                        st_q   <= ST_FALL;
                        step_q <= {2'b00, hz_step};
                    end
                endcase
            end
        end
    end

    assign bus.step     = step_q;
    assign bus.state    = st_q;
    assign bus.rise_cnt = rise_q;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl with TICK_DIV=4, JUMP_H=3.
// Outputs are checked on the falling edge; inputs change on the falling edge.
// A small tick-phase model tracks where the next motion tick lands.
module tb_char_motion_ctrl;

    logic sys_clk;
    logic sys_rst_n;

    char_motion_ctrl_if bif ();

    char_motion_ctrl #(
        .TICK_DIV (4),
        .JUMP_H   (3),
        .X_MIN    (0),
        .X_MAX    (639)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bif.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int cnt   = 0;    // modelled tick counter
    bit tk    = 0;    // last clock edge was a tick

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: rising edge, update tick model, land on the next falling edge.
    task automatic cyc();
        @(posedge sys_clk);
        tk = bif.en && (cnt == 3);
        if (bif.en) cnt = (cnt == 3) ? 0 : cnt + 1;
        @(negedge sys_clk);
    endtask

    // Advance until just after the next tick; non-tick cycles must be pulse-free.
    task automatic adv_to_tick();
        int guard;
        guard = 0;
        tk = 0;
        while (!tk && guard < 8) begin
            cyc();
            guard++;
            if (!tk) chk("idle_step", {4'b0, bif.step}, 8'h00);
        end
        if (!tk) begin
            total++;
            bad++;
            $error("FAIL tick_timeout observed=none expected=tick");
        end
    endtask

    initial begin
        sys_rst_n     = 1'b0;
        bif.en        = 1'b1;
        bif.key_lr    = 2'b00;
        bif.jump_btn  = 1'b0;
        bif.char_x    = 10'd100;
        bif.blk_up    = 1'b0;
        bif.blk_down  = 1'b0;
        bif.blk_left  = 1'b0;
        bif.blk_right = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Reset values.
        chk("rst_state", {6'b0, bif.state}, 8'h02);
        chk("rst_rise",  {2'b0, bif.rise_cnt}, 8'h00);
        chk("rst_step",  {4'b0, bif.step}, 8'h00);

        // Fall after reset: down pulses after edges 4,8,12; land on edge 16.
        sys_rst_n = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc();
            chk("fall_step", {4'b0, bif.step}, (i % 4 == 0 && i < 16) ? 8'h04 : 8'h00);
            if (i == 12) bif.blk_down = 1'b1;
        end
        chk("landed_state", {6'b0, bif.state}, 8'h00);

        // Full jump to apex JUMP_H=3.
        bif.jump_btn = 1'b1;
        cyc();
        bif.jump_btn = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            adv_to_tick();
            chk("jump_step",  {4'b0, bif.step}, 8'h08);
            chk("jump_state", {6'b0, bif.state}, 8'h01);
            chk("jump_rise",  {2'b0, bif.rise_cnt}, 8'(k));
        end
        adv_to_tick();
        chk("apex_step",  {4'b0, bif.step}, 8'h00);
        chk("apex_state", {6'b0, bif.state}, 8'h02);
        chk("apex_rise",  {2'b0, bif.rise_cnt}, 8'h03);
        adv_to_tick();
        chk("reland_state", {6'b0, bif.state}, 8'h00);
        chk("reland_rise",  {2'b0, bif.rise_cnt}, 8'h00);

        // Head bump on first rise step.
        bif.jump_btn = 1'b1;
        cyc();
        bif.jump_btn = 1'b0;
        adv_to_tick();
        chk("bump_rise1", {2'b0, bif.rise_cnt}, 8'h01);
        bif.blk_up = 1'b1;
        adv_to_tick();
        chk("bump_step",  {4'b0, bif.step}, 8'h00);
        chk("bump_state", {6'b0, bif.state}, 8'h02);
        chk("bump_rise",  {2'b0, bif.rise_cnt}, 8'h01);
        bif.blk_up = 1'b0;
        adv_to_tick();
        chk("bump_land_state", {6'b0, bif.state}, 8'h00);
        chk("bump_land_rise",  {2'b0, bif.rise_cnt}, 8'h00);

        // Horizontal moves while standing.
        bif.key_lr = 2'b10; bif.char_x = 10'd0;
        adv_to_tick();
        chk("left_at_min", {4'b0, bif.step}, 8'h00);
        bif.char_x = 10'd5;
        adv_to_tick();
        chk("left_ok1", {4'b0, bif.step}, 8'h02);
        adv_to_tick();
        chk("left_ok2", {4'b0, bif.step}, 8'h02);
        bif.key_lr = 2'b11;
        adv_to_tick();
        chk("both_keys", {4'b0, bif.step}, 8'h00);
        bif.key_lr = 2'b01; bif.blk_right = 1'b1;
        adv_to_tick();
        chk("right_blocked", {4'b0, bif.step}, 8'h00);
        bif.blk_right = 1'b0; bif.char_x = 10'd639;
        adv_to_tick();
        chk("right_at_max", {4'b0, bif.step}, 8'h00);
        bif.char_x = 10'd638;
        adv_to_tick();
        chk("right_ok", {4'b0, bif.step}, 8'h01);
        bif.key_lr = 2'b10; bif.blk_left = 1'b1; bif.char_x = 10'd5;
        adv_to_tick();
        chk("left_blocked", {4'b0, bif.step}, 8'h00);
        bif.blk_left = 1'b0; bif.key_lr = 2'b00; bif.char_x = 10'd100;

        // Walk off a ledge, then diagonal fall.
        bif.blk_down = 1'b0;
        adv_to_tick();
        chk("ledge_step",  {4'b0, bif.step}, 8'h00);
        chk("ledge_state", {6'b0, bif.state}, 8'h02);
        bif.key_lr = 2'b01;
        adv_to_tick();
        chk("diag_step", {4'b0, bif.step}, 8'h05);
        bif.key_lr = 2'b00;

        // Jump pressed mid-fall is dropped.
        bif.jump_btn = 1'b1;
        cyc();
        bif.jump_btn = 1'b0;
        adv_to_tick();
        chk("fall_jump_step",  {4'b0, bif.step}, 8'h04);
        chk("fall_jump_state", {6'b0, bif.state}, 8'h02);
        bif.blk_down = 1'b1;
        adv_to_tick();
        chk("fall_jump_land", {6'b0, bif.state}, 8'h00);
        adv_to_tick();
        chk("no_late_jump_state", {6'b0, bif.state}, 8'h00);
        chk("no_late_jump_step",  {4'b0, bif.step}, 8'h00);

        // Pause two cycles into a tick period; counter must resume from its held phase.
        cyc();
        cyc();
        bif.key_lr = 2'b01;
        bif.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) bif.jump_btn = 1'b1;
            if (i == 5) bif.jump_btn = 1'b0;
            cyc();
            chk("pause_step", {4'b0, bif.step}, 8'h00);
        end
        bif.en = 1'b1;
        cyc();
        chk("resume_pre", {4'b0, bif.step}, 8'h00);
        cyc();
        chk("resume_tick", {4'b0, bif.step}, 8'h01);
        chk("resume_state", {6'b0, bif.state}, 8'h00);
        bif.key_lr = 2'b00;

        // Asynchronous reset in the middle of a jump.
        bif.jump_btn = 1'b1;
        cyc();
        bif.jump_btn = 1'b0;
        adv_to_tick();
        adv_to_tick();
        chk("pre_rst_rise", {2'b0, bif.rise_cnt}, 8'h02);
        chk("pre_rst_step", {4'b0, bif.step}, 8'h08);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("arst_state", {6'b0, bif.state}, 8'h02);
        chk("arst_step",  {4'b0, bif.step}, 8'h00);
        chk("arst_rise",  {2'b0, bif.rise_cnt}, 8'h00);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        cnt = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
